// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load results into the
// register file's single write port and exports a per-register pending mask.
module wb_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   reg_write,
  output logic [ADDR_W-1:0]      sel_d,
  output logic [DATA_W-1:0]      data_in,
  output logic [(1<<ADDR_W)-1:0] pending
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  // Load-result FIFO storage (data-only, no reset needed: validity comes from count)
  logic [ADDR_W-1:0] fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [StW-1:0]    starve_cnt_q, starve_cnt_d;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] sel_d_q, sel_d_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;

  logic              fifo_empty;
  logic              force_fifo;
  logic              alu_commit;
  logic              push;
  logic              pop;
  logic [PtrW-1:0]   slot_off;

  // Arbitration: ALU wins unless the FIFO has been starved long enough
  always_comb begin
    fifo_empty = (count_q == '0);
    force_fifo = !fifo_empty && (starve_cnt_q == StW'(STARVE_MAX));
    alu_ready  = !force_fifo;
    mem_ready  = (count_q < CntW'(FIFO_DEPTH));
    alu_commit = alu_valid && alu_ready;
    pop        = !fifo_empty && !alu_commit;
    push       = mem_valid && mem_ready;
  end

  // FIFO pointer/count and starvation counter next state
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    starve_cnt_d = starve_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) count_d = count_q + CntW'(1);
    if (pop && !push) count_d = count_q - CntW'(1);
    if (fifo_empty || pop) begin
      starve_cnt_d = '0;
    end else if (alu_commit) begin
      starve_cnt_d = starve_cnt_q + StW'(1);
    end
  end

  // Output stage next state; index/data hold when idle
  always_comb begin
    reg_write_d = 1'b0;
    sel_d_d     = sel_d_q;
    data_in_d   = data_in_q;
    if (alu_commit) begin
      reg_write_d = 1'b1;
      sel_d_d     = alu_rd;
      data_in_d   = alu_data;
    end else if (pop) begin
      reg_write_d = 1'b1;
      sel_d_d     = fifo_rd_q[rd_ptr_q];
      data_in_d   = fifo_data_q[rd_ptr_q];
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      reg_write_q  <= 1'b0;
      sel_d_q      <= '0;
      data_in_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      reg_write_q  <= reg_write_d;
      sel_d_q      <= sel_d_d;
      data_in_q    <= data_in_d;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= mem_rd;
      fifo_data_q[wr_ptr_q] <= mem_data;
    end
  end

  // Pending mask: committing write plus every occupied FIFO slot
  always_comb begin
    pending  = '0;
    slot_off = '0;
    if (reg_write_q) pending[sel_d_q] = 1'b1;
    for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
      // Slot j is occupied when its distance from the head is below count
      slot_off = PtrW'(j) - rd_ptr_q;
      if ({1'b0, slot_off} < count_q) pending[fifo_rd_q[j]] = 1'b1;
    end
  end

  assign reg_write = reg_write_q;
  assign sel_d     = sel_d_q;
  assign data_in   = data_in_q;

endmodule
